// File: rtl/ingress_reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ingress_reset_sequencer
// Purpose  : Enables ingress domain clocks, then releases each domain's reset
//            after a per-domain delay; warm reset re-runs the release order.
// Revision : 1.0  initial release
// ============================================================================
module ingress_reset_sequencer #(
  parameter int NUM_DOMAINS = 2,
  parameter int CNT_W       = 16,
  parameter int CLK_LEAD    = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                         clock,
  input  logic                         power_good_reset_n,
  input  logic [NUM_DOMAINS-1:0]       domain_mask,
  input  logic [NUM_DOMAINS*CNT_W-1:0] dly_cfg,
  input  logic                         warm_reset_req,
  output logic                         warm_reset_ack,
  output logic [NUM_DOMAINS-1:0]       enable_clock,
  output logic [NUM_DOMAINS-1:0]       domain_reset,
  output logic                         seq_busy,
  output logic                         seq_done
);

  localparam int               IDX_W       = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [CNT_W-1:0] C_LEAD_LAST = CNT_W'(CLK_LEAD - 1);
  localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_CLK_EN    = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_DONE      = 3'd3,
    ST_WARM_HOLD = 3'd4
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_idx, w_idx_nxt, w_idx_inc;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]       r_dly, w_dly_nxt;
  logic [NUM_DOMAINS-1:0] r_mask, w_mask_nxt;
  logic [NUM_DOMAINS-1:0] w_en_nxt, w_rst_nxt;
  logic                   w_ack_nxt, w_busy_nxt, w_done_nxt;

  logic [CNT_W-1:0] w_dly_arr [NUM_DOMAINS];

  generate
    for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_dly_view
      assign w_dly_arr[g] = dly_cfg[g*CNT_W +: CNT_W];
    end
  endgenerate

  assign w_idx_inc = r_idx + IDX_W'(1);

  always_ff @(posedge clock or negedge power_good_reset_n) begin
    if (!power_good_reset_n) begin
      r_state        <= ST_RESET;
      r_idx          <= '0;
      r_cnt          <= '0;
      r_dly          <= '0;
      r_mask         <= '0;
      enable_clock   <= '0;
      domain_reset   <= '1;
      warm_reset_ack <= 1'b0;
      seq_busy       <= 1'b0;
      seq_done       <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_idx          <= w_idx_nxt;
      r_cnt          <= w_cnt_nxt;
      r_dly          <= w_dly_nxt;
      r_mask         <= w_mask_nxt;
      enable_clock   <= w_en_nxt;
      domain_reset   <= w_rst_nxt;
      warm_reset_ack <= w_ack_nxt;
      seq_busy       <= w_busy_nxt;
      seq_done       <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_dly_nxt   = r_dly;
    w_mask_nxt  = r_mask;
    w_en_nxt    = enable_clock;
    w_rst_nxt   = domain_reset;
    w_ack_nxt   = 1'b0;
    w_busy_nxt  = seq_busy;
    w_done_nxt  = seq_done;

    case (r_state)
      ST_RESET: begin
        w_state_nxt = ST_CLK_EN;
        w_mask_nxt  = domain_mask;
        w_en_nxt    = domain_mask;
        w_busy_nxt  = 1'b1;
        w_cnt_nxt   = '0;
      end

      ST_CLK_EN, ST_WARM_HOLD: begin
        if (r_cnt == ((r_state == ST_CLK_EN) ? C_LEAD_LAST : C_HOLD_LAST)) begin
          w_state_nxt = ST_RELEASE;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
          w_dly_nxt   = w_dly_arr[0];
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      // Counter stops at equality with the sampled delay, so all-ones never wraps.
      ST_RELEASE: begin
        if (!r_mask[r_idx] || (r_cnt == r_dly)) begin
          if (r_mask[r_idx]) begin
            w_rst_nxt[r_idx] = 1'b0;
          end
          if (r_idx == C_IDX_LAST) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
          end else begin
            w_idx_nxt = w_idx_inc;
            w_cnt_nxt = '0;
            w_dly_nxt = w_dly_arr[w_idx_inc];
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      // Unmasked domains always sit in reset, so every reset reasserts here.
      ST_DONE: begin
        if (warm_reset_req) begin
          w_state_nxt = ST_WARM_HOLD;
          w_ack_nxt   = 1'b1;
          w_mask_nxt  = domain_mask;
          w_en_nxt    = domain_mask;
          w_rst_nxt   = '1;
          w_done_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end
      end

      default: begin
        w_state_nxt = ST_RESET;
      end
    endcase
  end

endmodule
`default_nettype wire
